// File: rtl/stepper_pkg.sv
// Shared stepper definitions, used by both the step/dir generator and this receiver.
//   step_rx_state_t : receiver pulse-qualifier states
//   POS_W_DFLT      : default signed position width
//   PER_W_DFLT      : default unsigned step-period width
package stepper_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    QUAL = 2'd1,
    HIGH = 2'd2
  } step_rx_state_t;

  localparam int POS_W_DFLT = 32;
  localparam int PER_W_DFLT = 24;

endpackage

// File: rtl/step_dir_decoder_if.sv
// Host-side bundle of the step/dir receiver.
//   master : drives the raw step/dir lines and the clear strobes, reads the readback
//   slave  : the decoder itself
//   step_in, dir_in       raw asynchronous lines
//   clear_pos, clear_err  synchronous strobes
//   position, step_evt, step_period, moving, dir_err, glitch_err  readback
interface step_dir_decoder_if
  import stepper_pkg::*;
#(
  parameter int POS_W = POS_W_DFLT,
  parameter int PER_W = PER_W_DFLT
) ();

  logic                    step_in;
  logic                    dir_in;
  logic                    clear_pos;
  logic                    clear_err;
  logic signed [POS_W-1:0] position;
  logic                    step_evt;
  logic        [PER_W-1:0] step_period;
  logic                    moving;
  logic                    dir_err;
  logic                    glitch_err;

  modport master (
    output step_in, dir_in, clear_pos, clear_err,
    input  position, step_evt, step_period, moving, dir_err, glitch_err
  );

  modport slave (
    input  step_in, dir_in, clear_pos, clear_err,
    output position, step_evt, step_period, moving, dir_err, glitch_err
  );

endinterface

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for one asynchronous input, cleared to 0 on reset.
//   clk   : system clock
//   reset : asynchronous, active-high
//   d_i   : asynchronous input
//   q_o   : synchronised output, N cycles behind d_i
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/step_dir_decoder.sv
// Receiving end of the step/dir motor interface. Synchronises the raw lines, rejects
// short step glitches, accumulates signed position, measures the step period and flags
// steps taken while dir was still settling.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : step_dir_decoder_if.slave (raw lines, clear strobes, readback)
//
// state | meaning
// LOW   | step_s low, waiting for a rising pulse
// QUAL  | step_s high, counting samples towards MIN_PULSE
// HIGH  | step accepted, waiting for step_s to fall
module step_dir_decoder
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int DIR_SETUP   = 4,
  parameter int POS_W       = POS_W_DFLT,
  parameter int PER_W       = PER_W_DFLT,
  parameter int TIMEOUT     = 50000
) (
  input logic              clk,
  input logic              reset,
  step_dir_decoder_if.slave bus
);

  localparam logic [1:0] S_LOW  = LOW;
  localparam logic [1:0] S_QUAL = QUAL;
  localparam logic [1:0] S_HIGH = HIGH;

  localparam int HCNT_W = $clog2(MIN_PULSE + 1);
  localparam int DCNT_W = $clog2(DIR_SETUP + 1);

  localparam logic [HCNT_W-1:0] MIN_PULSE_C = HCNT_W'(MIN_PULSE);
  localparam logic [DCNT_W-1:0] DIR_SETUP_C = DCNT_W'(DIR_SETUP);
  localparam logic [PER_W-1:0]  PCNT_MAX    = {PER_W{1'b1}};
  localparam logic [PER_W-1:0]  TIMEOUT_M1  = PER_W'(TIMEOUT - 1);

  logic step_s;
  logic dir_s;

  logic [1:0]              state_q,   state_d;
  logic [HCNT_W-1:0]       hcnt_q,    hcnt_d;
  logic [DCNT_W-1:0]       dcnt_q,    dcnt_d;
  logic                    dir_prev_q;
  logic signed [POS_W-1:0] pos_q,     pos_d;
  logic [PER_W-1:0]        pcnt_q,    pcnt_d;
  logic [PER_W-1:0]        per_q,     per_d;
  logic                    moving_q,  moving_d;
  logic                    evt_q;
  logic                    dir_err_q, dir_err_d;
  logic                    gl_err_q,  gl_err_d;

  logic                    accept;
  logic                    glitch;
  logic                    dir_chg;
  logic                    dir_short;
  logic signed [POS_W-1:0] pos_base;
  logic [PER_W-1:0]        pcnt_inc;

  sync_ff #(.N(SYNC_STAGES)) u_sync_step (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.step_in),
    .q_o   (step_s)
  );

  sync_ff #(.N(SYNC_STAGES)) u_sync_dir (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.dir_in),
    .q_o   (dir_s)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    accept  = 1'b0;
    glitch  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (step_s) begin
          if (MIN_PULSE <= 1) begin
            accept  = 1'b1;
            state_d = S_HIGH;
          end else begin
            hcnt_d  = HCNT_W'(1);
            state_d = S_QUAL;
          end
        end
      end
      S_QUAL: begin
        if (step_s) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
          if (hcnt_d == MIN_PULSE_C) begin
            accept  = 1'b1;
            state_d = S_HIGH;
          end
        end else begin
          glitch  = 1'b1;
          state_d = S_LOW;
        end
      end
      S_HIGH: begin
        if (!step_s) begin
          state_d = S_LOW;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // A dir edge seen in the accept cycle itself counts as zero stability.
  always_comb begin
    dir_chg   = (dir_s != dir_prev_q);
    dir_short = dir_chg || (dcnt_q < DIR_SETUP_C);
    if (dir_chg) begin
      dcnt_d = '0;
    end else if (dcnt_q == DIR_SETUP_C) begin
      dcnt_d = dcnt_q;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end
  end

  // Homing clear is applied before the step so a coincident step counts from zero.
  always_comb begin
    pos_base = bus.clear_pos ? '0 : pos_q;
    pos_d    = pos_base;
    if (accept) begin
      pos_d = dir_s ? (pos_base + POS_W'(1)) : (pos_base - POS_W'(1));
    end
  end

  always_comb begin
    pcnt_inc = (pcnt_q == PCNT_MAX) ? pcnt_q : (pcnt_q + PER_W'(1));
    pcnt_d   = accept ? '0 : pcnt_inc;
    per_d    = (accept && moving_q) ? pcnt_inc : per_q;
    if (accept) begin
      moving_d = 1'b1;
    end else if (pcnt_q >= TIMEOUT_M1) begin
      moving_d = 1'b0;
    end else begin
      moving_d = moving_q;
    end
    // A new error in the same cycle as clear_err keeps the flag set.
    dir_err_d = (accept && dir_short) || (dir_err_q && !bus.clear_err);
    gl_err_d  = glitch || (gl_err_q && !bus.clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOW;
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      dir_prev_q <= 1'b0;
      pos_q      <= '0;
      pcnt_q     <= '0;
      per_q      <= '0;
      moving_q   <= 1'b0;
      evt_q      <= 1'b0;
      dir_err_q  <= 1'b0;
      gl_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      dir_prev_q <= dir_s;
      pos_q      <= pos_d;
      pcnt_q     <= pcnt_d;
      per_q      <= per_d;
      moving_q   <= moving_d;
      evt_q      <= accept;
      dir_err_q  <= dir_err_d;
      gl_err_q   <= gl_err_d;
    end
  end

  assign bus.position    = pos_q;
  assign bus.step_evt    = evt_q;
  assign bus.step_period = per_q;
  assign bus.moving      = moving_q;
  assign bus.dir_err     = dir_err_q;
  assign bus.glitch_err  = gl_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: pulses push their expected position into a scoreboard
// queue when driven; a negedge monitor pops and compares on every step_evt.
module tb_step_dir_decoder;

  localparam int TIMEOUT = 50000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic signed [31:0] exp_pos = '0;
  logic signed [31:0] mon_exp;
  logic signed [31:0] sb_q[$];

  step_dir_decoder_if bus_if ();

  step_dir_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!reset && bus_if.step_evt === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_step: position %h, required no accepted step", bus_if.position);
      end else begin
        mon_exp = sb_q.pop_front();
        if (bus_if.position !== mon_exp) begin
          miscompares++;
          $display("FAIL step_position: got %h, want %h", bus_if.position, mon_exp);
        end
      end
    end
  end

  task automatic apply_reset();
    reset = 1'b1;
    bus_if.step_in   = 1'b0;
    bus_if.clear_pos = 1'b0;
    bus_if.clear_err = 1'b0;
    exp_pos = '0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Rising edge at the first negedge; hi cycles high, lo cycles low.
  task automatic pulse(input int hi, input int lo);
    @(negedge clk);
    if (hi >= 2) begin
      exp_pos = bus_if.dir_in ? exp_pos + 32'sd1 : exp_pos - 32'sd1;
      sb_q.push_back(exp_pos);
    end
    bus_if.step_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus_if.step_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    bus_if.dir_in = 1'b0;
    apply_reset();
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus_if.position !== 32'sd0 || bus_if.step_period !== 24'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got pos %h per %h, want 0 0", bus_if.position, bus_if.step_period);
    end
    vectors++;
    if ({bus_if.step_evt, bus_if.moving, bus_if.dir_err, bus_if.glitch_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, want 0000",
               {bus_if.step_evt, bus_if.moving, bus_if.dir_err, bus_if.glitch_err});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_pulse();
    int lat;
    bus_if.dir_in = 1'b1;
    apply_reset();
    repeat (10) @(negedge clk);
    exp_pos = exp_pos + 32'sd1;
    sb_q.push_back(exp_pos);
    bus_if.step_in = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 3) bus_if.step_in = 1'b0;
      if (bus_if.step_evt === 1'b1) lat = k;
    end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL accept_latency: got %0d edges, want 4", lat);
    end
    @(negedge clk);
    vectors++;
    if (bus_if.step_evt !== 1'b0) begin
      miscompares++;
      $display("FAIL step_evt_width: got %b one cycle later, want 0", bus_if.step_evt);
    end
    vectors++;
    if (bus_if.step_period !== 24'd0 || bus_if.moving !== 1'b1) begin
      miscompares++;
      $display("FAIL first_step: got per %0d moving %b, want 0 1", bus_if.step_period, bus_if.moving);
    end
  endtask

  task automatic test_run();
    bus_if.dir_in = 1'b1;
    apply_reset();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3590; i++) pulse(2, 3);
    for (int i = 0; i < 10; i++) pulse(20, 80);
    repeat (10) @(negedge clk);
    vectors++;
    if (bus_if.position !== 32'sd3600) begin
      miscompares++;
      $display("FAIL run_position: got %0d, want 3600", bus_if.position);
    end
    vectors++;
    if (bus_if.step_period !== 24'd100) begin
      miscompares++;
      $display("FAIL run_period: got %0d, want 100", bus_if.step_period);
    end
    vectors++;
    if ({bus_if.moving, bus_if.dir_err, bus_if.glitch_err} !== 3'b100) begin
      miscompares++;
      $display("FAIL run_flags: got %b, want 100", {bus_if.moving, bus_if.dir_err, bus_if.glitch_err});
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL run_drain: got %0d pending steps, want 0", sb_q.size());
    end
  endtask

  task automatic test_glitch();
    pulse(1, 10);
    vectors++;
    if (bus_if.position !== exp_pos || bus_if.glitch_err !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_reject: got pos %h gerr %b, want %h 1", bus_if.position, bus_if.glitch_err, exp_pos);
    end
    bus_if.clear_err = 1'b1;
    @(negedge clk);
    bus_if.clear_err = 1'b0;
    vectors++;
    if (bus_if.glitch_err !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_clear: got %b, want 0", bus_if.glitch_err);
    end
    // clear_err lands on the same edge that detects the next glitch.
    @(negedge clk); bus_if.step_in = 1'b1;
    @(negedge clk); bus_if.step_in = 1'b0;
    @(negedge clk);
    @(negedge clk); bus_if.clear_err = 1'b1;
    @(negedge clk); bus_if.clear_err = 1'b0;
    vectors++;
    if (bus_if.glitch_err !== 1'b1) begin
      miscompares++;
      $display("FAIL error_wins: got %b, want 1", bus_if.glitch_err);
    end
    bus_if.clear_err = 1'b1;
    @(negedge clk);
    bus_if.clear_err = 1'b0;
  endtask

  task automatic test_dir_err();
    @(negedge clk);
    bus_if.dir_in = 1'b0;
    pulse(3, 10);
    vectors++;
    if (bus_if.dir_err !== 1'b1 || bus_if.position !== exp_pos) begin
      miscompares++;
      $display("FAIL dir_setup: got derr %b pos %h, want 1 %h", bus_if.dir_err, bus_if.position, exp_pos);
    end
    bus_if.clear_err = 1'b1;
    @(negedge clk);
    bus_if.clear_err = 1'b0;
    repeat (10) @(negedge clk);
    pulse(3, 10);
    vectors++;
    if (bus_if.dir_err !== 1'b0 || bus_if.position !== exp_pos) begin
      miscompares++;
      $display("FAIL dir_stable: got derr %b pos %h, want 0 %h", bus_if.dir_err, bus_if.position, exp_pos);
    end
  endtask

  task automatic test_wrap();
    bus_if.dir_in = 1'b1;
    repeat (10) @(negedge clk);
    force dut.pos_q = 32'h7FFF_FFFE;
    @(negedge clk);
    release dut.pos_q;
    exp_pos = 32'sh7FFF_FFFE;
    pulse(3, 10);
    pulse(3, 10);
    vectors++;
    if (bus_if.position !== 32'sh8000_0000) begin
      miscompares++;
      $display("FAIL wrap: got %h, want 80000000", bus_if.position);
    end
    bus_if.dir_in = 1'b0;
    repeat (10) @(negedge clk);
    exp_pos = -32'sd1;
    sb_q.push_back(exp_pos);
    bus_if.step_in = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.step_in   = 1'b0;
    bus_if.clear_pos = 1'b1;
    @(negedge clk);
    bus_if.clear_pos = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (bus_if.position !== -32'sd1) begin
      miscompares++;
      $display("FAIL clear_on_accept: got %h, want ffffffff", bus_if.position);
    end
  endtask

  task automatic test_timeout();
    bit seen;
    bus_if.dir_in = 1'b1;
    repeat (10) @(negedge clk);
    pulse(3, 97);
    @(negedge clk);
    exp_pos = exp_pos + 32'sd1;
    sb_q.push_back(exp_pos);
    bus_if.step_in = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (k == 3) bus_if.step_in = 1'b0;
      if (bus_if.step_evt === 1'b1) seen = 1'b1;
    end
    bus_if.step_in = 1'b0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout_last_step: got no step_evt within 10 edges, want one");
    end
    repeat (TIMEOUT - 1) @(negedge clk);
    vectors++;
    if (bus_if.moving !== 1'b1) begin
      miscompares++;
      $display("FAIL moving_hold: got %b at TIMEOUT-1, want 1", bus_if.moving);
    end
    @(negedge clk);
    vectors++;
    if (bus_if.moving !== 1'b0 || bus_if.step_period !== 24'd100) begin
      miscompares++;
      $display("FAIL moving_timeout: got moving %b per %0d, want 0 100", bus_if.moving, bus_if.step_period);
    end
  endtask

  task automatic test_reset_mid_qual();
    @(negedge clk);
    bus_if.step_in = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({bus_if.position, bus_if.step_period, bus_if.step_evt, bus_if.moving, bus_if.dir_err,
         bus_if.glitch_err} !== 60'd0) begin
      miscompares++;
      $display("FAIL reset_mid_qual: got pos %h per %h flags %b, want all 0", bus_if.position,
               bus_if.step_period, {bus_if.step_evt, bus_if.moving, bus_if.dir_err, bus_if.glitch_err});
    end
    bus_if.step_in = 1'b0;
    exp_pos = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (bus_if.position !== 32'sd0 || bus_if.glitch_err !== 1'b0 || bus_if.moving !== 1'b0) begin
      miscompares++;
      $display("FAIL dropped_pulse: got pos %h gerr %b moving %b, want 0 0 0", bus_if.position,
               bus_if.glitch_err, bus_if.moving);
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: got %0d pending steps, want 0", sb_q.size());
    end
  endtask

  initial begin
    bus_if.step_in   = 1'b0;
    bus_if.dir_in    = 1'b0;
    bus_if.clear_pos = 1'b0;
    bus_if.clear_err = 1'b0;
    test_reset();
    test_single_pulse();
    test_run();
    test_glitch();
    test_dir_err();
    test_wrap();
    test_timeout();
    test_reset_mid_qual();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
